// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate game sequencer for the pong ball datapath.
// Runs IDLE -> SERVE -> PLAY -> POINT/OVER, starts/stops ball motion, detects
// paddle hits and misses at the field edges and keeps both player scores.
// Ports:
//   clk25M, reset             pixel clock, synchronous active-high reset
//   x, y                      raster position (end-of-frame marker detection)
//   start_btn                 debounced start/restart level
//   ball_x, ball_y            ball top-left corner
//   paddle_l_y, paddle_r_y    paddle top coordinates
//   ball_run, ball_load       ball motion enable / 1-cycle centre reload pulse
//   serve_dir                 launch direction (1 = right), valid with ball_load
//   hit_l, hit_r              1-cycle paddle-hit pulses
//   score_l, score_r          player scores
//   game_over, state          OVER flag and phase code for display
module pong_game_ctrl #(
  parameter int unsigned BALL_SIZE    = 10,
  parameter int unsigned PADDLE_H     = 48,
  parameter int unsigned LEFT_EDGE    = 30,
  parameter int unsigned RIGHT_EDGE   = 600,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned FRAME_X      = 0,
  parameter int unsigned FRAME_Y      = 481
) (
  input  logic       clk25M,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       start_btn,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic       ball_run,
  output logic       ball_load,
  output logic       serve_dir,
  output logic       hit_l,
  output logic       hit_r,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
  logic               serve_dir_q, serve_dir_d;
  logic               ball_run_q, ball_run_d;
  logic               ball_load_q, ball_load_d;
  logic               hit_l_q, hit_l_d, hit_r_q, hit_r_d;
  logic               game_over_q, game_over_d;
  logic               lock_l_q, lock_l_d, lock_r_q, lock_r_d;
  logic               start_q;
  logic               frame_tick_q;

  logic               start_rise;
  logic [10:0]        bx, by, by_bot, pl, pr;
  logic               overlap_l, overlap_r, at_left, at_right;
  logic [3:0]         new_l, new_r;

  // Edge geometry in 11 bits so ball + size never wraps past 1023.
  always_comb begin
    bx        = {1'b0, ball_x};
    by        = {1'b0, ball_y};
    pl        = {1'b0, paddle_l_y};
    pr        = {1'b0, paddle_r_y};
    by_bot    = by + 11'(BALL_SIZE - 1);
    overlap_l = (by_bot >= pl) && (by <= pl + 11'(PADDLE_H - 1));
    overlap_r = (by_bot >= pr) && (by <= pr + 11'(PADDLE_H - 1));
    at_left   = (bx <= 11'(LEFT_EDGE));
    at_right  = (bx + 11'(BALL_SIZE - 1) >= 11'(RIGHT_EDGE));
    start_rise = start_btn & ~start_q;
    new_l     = score_l_q + 4'd1;
    new_r     = score_r_q + 4'd1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    lock_l_d    = lock_l_q;
    lock_r_d    = lock_r_q;
    ball_load_d = 1'b0;
    hit_l_d     = 1'b0;
    hit_r_d     = 1'b0;

    // A lock holds off repeat hits until the ball has left that edge.
    if (frame_tick_q) begin
      if (!at_left)  lock_l_d = 1'b0;
      if (!at_right) lock_r_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          ball_load_d = 1'b1;
          cnt_d       = CNT_W'(SERVE_FRAMES);
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick_q) begin
          if (cnt_q == CNT_W'(1)) state_d = ST_PLAY;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_PLAY: begin
        if (frame_tick_q) begin
          if (at_left) begin
            if (lock_l_q) begin
              // still leaving the left edge after a hit
            end else if (overlap_l) begin
              hit_l_d  = 1'b1;
              lock_l_d = 1'b1;
            end else begin
              score_r_d   = new_r;
              serve_dir_d = 1'b0;
              if (new_r == 4'(WIN_SCORE)) state_d = ST_OVER;
              else begin
                state_d = ST_POINT;
                cnt_d   = CNT_W'(POINT_FRAMES);
              end
            end
          end else if (at_right) begin
            if (lock_r_q) begin
              // still leaving the right edge after a hit
            end else if (overlap_r) begin
              hit_r_d  = 1'b1;
              lock_r_d = 1'b1;
            end else begin
              score_l_d   = new_l;
              serve_dir_d = 1'b1;
              if (new_l == 4'(WIN_SCORE)) state_d = ST_OVER;
              else begin
                state_d = ST_POINT;
                cnt_d   = CNT_W'(POINT_FRAMES);
              end
            end
          end
        end
      end
      ST_POINT: begin
        if (frame_tick_q) begin
          if (cnt_q == CNT_W'(1)) begin
            ball_load_d = 1'b1;
            cnt_d       = CNT_W'(SERVE_FRAMES);
            state_d     = ST_SERVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_dir_d = ~serve_dir_q;
          ball_load_d = 1'b1;
          cnt_d       = CNT_W'(SERVE_FRAMES);
          state_d     = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ball_run_d  = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers; start_q resets high so a held button is ignored.
  always_ff @(posedge clk25M) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      serve_dir_q  <= 1'b1;
      ball_run_q   <= 1'b0;
      ball_load_q  <= 1'b0;
      hit_l_q      <= 1'b0;
      hit_r_q      <= 1'b0;
      game_over_q  <= 1'b0;
      lock_l_q     <= 1'b0;
      lock_r_q     <= 1'b0;
      start_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      serve_dir_q  <= serve_dir_d;
      ball_run_q   <= ball_run_d;
      ball_load_q  <= ball_load_d;
      hit_l_q      <= hit_l_d;
      hit_r_q      <= hit_r_d;
      game_over_q  <= game_over_d;
      lock_l_q     <= lock_l_d;
      lock_r_q     <= lock_r_d;
      start_q      <= start_btn;
      frame_tick_q <= (x == 10'(FRAME_X)) && (y == 10'(FRAME_Y));
    end
  end

  assign ball_run  = ball_run_q;
  assign ball_load = ball_load_q;
  assign serve_dir = serve_dir_q;
  assign hit_l     = hit_l_q;
  assign hit_r     = hit_r_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game scenarios followed by random play,
// every cycle scored against a frame-level game model through a queue.
module tb_pong_game_ctrl;

  localparam int SF = 3, PF = 4, WS = 7, FX = 0, FY = 481;
  localparam int BS = 10, PH = 48, LE = 30, RE = 600;

  logic       clk25M = 1'b0;
  logic       reset, start_btn;
  logic [9:0] x, y, ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic       ball_run, ball_load, serve_dir, hit_l, hit_r, game_over;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  always #5 clk25M = ~clk25M;

  pong_game_ctrl #(.SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WS)) dut (
    .clk25M(clk25M), .reset(reset), .x(x), .y(y), .start_btn(start_btn),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_run(ball_run), .ball_load(ball_load), .serve_dir(serve_dir),
    .hit_l(hit_l), .hit_r(hit_r), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       run, load, dir, hl, hr;
    logic [3:0] sl, sr;
    logic       over;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int hits_seen = 0, loads_seen = 0;

  // Game model: phase 0..4, frame timer, scores, serve direction, edge locks.
  int m_ph, m_cnt, m_sl, m_sr;
  bit m_dir, m_lockl, m_lockr, m_tick, m_prev, m_load, m_hl, m_hr;

  function automatic bit overlaps(int by, int py);
    return (by + BS - 1 >= py) && (by <= py + PH - 1);
  endfunction

  task automatic award(input bit right_player);
    int s;
    if (right_player) begin m_sr++; s = m_sr; m_dir = 1'b0; end
    else              begin m_sl++; s = m_sl; m_dir = 1'b1; end
    if (s == WS) m_ph = 4;
    else begin m_ph = 3; m_cnt = PF; end
  endtask

  task automatic model_step();
    bit tick_now, rise;
    int bx, by;
    bx = int'(ball_x); by = int'(ball_y);
    if (reset) begin
      m_ph = 0; m_cnt = 0; m_sl = 0; m_sr = 0; m_dir = 1'b1;
      m_lockl = 1'b0; m_lockr = 1'b0; m_tick = 1'b0; m_prev = 1'b1;
      m_load = 1'b0; m_hl = 1'b0; m_hr = 1'b0;
    end else begin
      tick_now = m_tick;
      m_tick   = (int'(x) == FX) && (int'(y) == FY);
      rise     = start_btn && !m_prev;
      m_prev   = start_btn;
      m_load = 1'b0; m_hl = 1'b0; m_hr = 1'b0;
      if (tick_now) begin
        if (bx > LE) m_lockl = 1'b0;
        if (bx + BS - 1 < RE) m_lockr = 1'b0;
      end
      case (m_ph)
        0: if (rise) begin m_load = 1'b1; m_cnt = SF; m_ph = 1; end
        1: if (tick_now) begin if (m_cnt == 1) m_ph = 2; else m_cnt--; end
        2: if (tick_now) begin
             if (bx <= LE) begin
               if (!m_lockl) begin
                 if (overlaps(by, int'(paddle_l_y))) begin m_hl = 1'b1; m_lockl = 1'b1; end
                 else award(1'b1);
               end
             end else if (bx + BS - 1 >= RE) begin
               if (!m_lockr) begin
                 if (overlaps(by, int'(paddle_r_y))) begin m_hr = 1'b1; m_lockr = 1'b1; end
                 else award(1'b0);
               end
             end
           end
        3: if (tick_now) begin
             if (m_cnt == 1) begin m_load = 1'b1; m_cnt = SF; m_ph = 1; end
             else m_cnt--;
           end
        default: if (rise) begin
             m_sl = 0; m_sr = 0; m_dir = !m_dir; m_load = 1'b1; m_cnt = SF; m_ph = 1;
           end
      endcase
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.st = 3'(m_ph); o.run = (m_ph == 2); o.load = m_load; o.dir = m_dir;
    o.hl = m_hl; o.hr = m_hr; o.sl = 4'(m_sl); o.sr = 4'(m_sr); o.over = (m_ph == 4);
    return o;
  endfunction

  // One clock per iteration: model consumes the inputs the DUT sampled.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk25M);
      model_step();
      exp_q.push_back(model_obs());
      #3;
    end
  endtask

  task automatic frame();
    x = 10'(FX); y = 10'(FY);
    cyc(1);
    x = 10'd0; y = 10'd0;
    cyc(3);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic chk(input string name, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  // Monitor: pop the expected observation for each clock and compare.
  always @(posedge clk25M) begin
    obs_t e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {state, ball_run, ball_load, serve_dir, hit_l, hit_r, score_l, score_r, game_over};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cycle: got st=%0d run=%b load=%b dir=%b hl=%b hr=%b sl=%0d sr=%0d over=%b expected st=%0d run=%b load=%b dir=%b hl=%b hr=%b sl=%0d sr=%0d over=%b at %0t",
                 g.st, g.run, g.load, g.dir, g.hl, g.hr, g.sl, g.sr, g.over,
                 e.st, e.run, e.load, e.dir, e.hl, e.hr, e.sl, e.sr, e.over, $time);
      end
      if (hit_l === 1'b1) hits_seen++;
      if (ball_load === 1'b1) loads_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, l0;
    reset = 1'b1; start_btn = 1'b1; x = 10'd0; y = 10'd0;
    ball_x = 10'd300; ball_y = 10'd100; paddle_l_y = 10'd95; paddle_r_y = 10'd100;

    // 1: button held through reset does not start; a fresh press does
    cyc(3);
    chk("reset_state", int'(state), 0);
    chk("reset_dir", int'(serve_dir), 1);
    reset = 1'b0;
    cyc(3);
    chk("held_btn_idle", int'(state), 0);
    start_btn = 1'b0; cyc(1);
    start_btn = 1'b1; cyc(1);
    chk("start_load", int'(ball_load), 1);
    chk("start_state", int'(state), 1);
    start_btn = 1'b0; cyc(1);
    chk("load_pulse_end", int'(ball_load), 0);

    // 2: PLAY entered on exactly the SF-th frame tick
    frames(SF - 1);
    chk("serve_hold", int'(state), 1);
    chk("serve_run", int'(ball_run), 0);
    frame();
    chk("play_state", int'(state), 2);
    chk("play_run", int'(ball_run), 1);

    // 3: single hit while the ball lingers at the left edge
    h0 = hits_seen;
    ball_x = 10'd30; ball_y = 10'd100; paddle_l_y = 10'd95;
    frames(3);
    chk("single_hit_l", hits_seen - h0, 1);
    ball_x = 10'd300; frame();

    // 4: right miss, point pause, reserve
    ball_x = 10'd595; ball_y = 10'd300; paddle_r_y = 10'd100;
    frame();
    chk("miss_r_score_l", int'(score_l), 1);
    chk("miss_r_dir", int'(serve_dir), 1);
    chk("miss_r_state", int'(state), 3);
    ball_x = 10'd300;
    l0 = loads_seen;
    frames(PF - 1);
    chk("point_hold", int'(state), 3);
    frame();
    chk("point_reserve", int'(state), 1);
    chk("point_load", loads_seen - l0, 1);

    // 5: left misses up to the winning score, then restart
    for (int i = 0; i < WS; i++) begin
      ball_x = 10'd300; frames(SF);
      ball_x = 10'd10; ball_y = 10'd200; paddle_l_y = 10'd0;
      frame();
      ball_x = 10'd300;
      if (i < WS - 1) frames(PF);
    end
    chk("win_score_r", int'(score_r), WS);
    chk("win_state", int'(state), 4);
    chk("win_over", int'(game_over), 1);
    chk("win_dir", int'(serve_dir), 0);
    start_btn = 1'b1; cyc(1);
    chk("restart_sl", int'(score_l), 0);
    chk("restart_sr", int'(score_r), 0);
    chk("restart_dir", int'(serve_dir), 1);
    chk("restart_state", int'(state), 1);
    start_btn = 1'b0; cyc(1);

    // 6: reset in the middle of a game
    for (int i = 0; i < 3; i++) begin
      frames(SF);
      ball_x = 10'd595; ball_y = 10'd300; paddle_r_y = 10'd100;
      frame();
      ball_x = 10'd300;
      frames(PF);
    end
    frames(SF);
    chk("pre_reset_sl", int'(score_l), 3);
    chk("pre_reset_state", int'(state), 2);
    reset = 1'b1; cyc(1);
    chk("mid_reset_state", int'(state), 0);
    chk("mid_reset_sl", int'(score_l), 0);
    chk("mid_reset_run", int'(ball_run), 0);
    reset = 1'b0; cyc(1);

    // Random play against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 3) == 0) begin x = 10'(FX); y = 10'(FY); end
      else begin x = 10'($urandom_range(0, 1023)); y = 10'($urandom_range(0, 1023)); end
      case ($urandom_range(0, 3))
        0: ball_x = 10'($urandom_range(0, 1023));
        1: ball_x = 10'($urandom_range(20, 40));
        2: ball_x = 10'($urandom_range(585, 605));
        default: ball_x = 10'($urandom_range(200, 400));
      endcase
      ball_y = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 1) == 0) begin
        paddle_l_y = 10'($urandom_range(0, 479));
        paddle_r_y = 10'($urandom_range(0, 479));
      end else begin
        paddle_l_y = (ball_y > 10'd60) ? ball_y - 10'($urandom_range(0, 60)) : 10'd0;
        paddle_r_y = (ball_y > 10'd60) ? ball_y - 10'($urandom_range(0, 60)) : 10'd0;
      end
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);
    #2;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
